// File: rtl/sram_responder.sv
// sram_responder: on-chip stand-in for the external SRAM behind the CPU's
// active-low strobe interface. It accepts one access per strobe assertion,
// answers after a programmable latency with a single-cycle Ready pulse, and
// provides a backdoor port for loading the array while the bus is idle.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for an armed request; backdoor init allowed if CE=1
// ST_RD_WAIT | read accepted, counting down to completion (Ready + Data_out)
// ST_WR_WAIT | write already committed, counting down to the Ready pulse
module sram_responder #(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       A,
    input  logic              CE,
    input  logic              UB,
    input  logic              LB,
    input  logic              OE,
    input  logic              WE,
    input  logic [15:0]       Data_in,
    output logic [15:0]       Data_out,
    output logic              Ready,
    input  logic              Init_we,
    input  logic [ADDR_W-1:0] Init_addr,
    input  logic [15:0]       Init_data
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_armed;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ub;
    logic              r_lb;
    logic              r_oor;
    logic              r_ready;
    logic [15:0]       r_data_out;
    logic [15:0]       r_mem [0:DEPTH-1];

    logic              w_req;
    logic              w_accept;
    logic              w_wr_op;
    logic              w_oor_in;
    logic              w_done_nxt;
    logic              w_bus_we;
    logic              w_init_ok;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_ub;
    logic              w_rd_lb;
    logic              w_rd_oor;
    logic [15:0]       w_rd_word;
    logic [15:0]       w_rd_data;

    assign w_req    = ~CE & (~OE | ~WE);
    // WE low wins when both strobes are low, so that case is a write.
    assign w_wr_op  = ~WE;
    assign w_oor_in = ((A >> ADDR_W) != 16'd0);

    // Next-state and countdown; Ready is due whenever the next state is a
    // wait state whose counter has reached zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && r_armed) begin
                    w_accept = 1'b1;
                    if (w_wr_op) begin
                        w_state_nxt = ST_WR_WAIT;
                        w_cnt_nxt   = WR_LOAD;
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                        w_cnt_nxt   = RD_LOAD;
                    end
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_done_nxt = (w_state_nxt != ST_IDLE) && (w_cnt_nxt == '0);
    end

    // State, counter and the one-access-per-assertion arming flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_armed <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!w_req) begin
                r_armed <= 1'b1;
            end else if (w_accept) begin
                r_armed <= 1'b0;
            end
        end
    end

    // Capture the request on accept so later bus activity cannot disturb it.
    always_ff @(posedge Clk) begin
        if (w_accept && !Reset) begin
            r_addr <= A[ADDR_W-1:0];
            r_ub   <= UB;
            r_lb   <= LB;
            r_oor  <= w_oor_in;
        end
    end

    assign w_bus_we  = w_accept & w_wr_op & ~w_oor_in & ~Reset;
    assign w_init_ok = Init_we & (r_state == ST_IDLE) & CE & ~Reset;

    // Array update: bus writes commit on the accept edge, per byte lane; the
    // backdoor only gets in while the bus is idle and deselected. The array
    // has no reset so a program survives a CPU reset.
    always_ff @(posedge Clk) begin
        if (w_bus_we) begin
            if (!UB) begin
                r_mem[A[ADDR_W-1:0]][15:8] <= Data_in[15:8];
            end
            if (!LB) begin
                r_mem[A[ADDR_W-1:0]][7:0] <= Data_in[7:0];
            end
        end else if (w_init_ok) begin
            r_mem[Init_addr] <= Init_data;
        end
    end

    // With a one-cycle read latency the completion edge is the accept edge,
    // so the read path must look at the live bus instead of the capture regs.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_rd_addr = A[ADDR_W-1:0];
            w_rd_ub   = UB;
            w_rd_lb   = LB;
            w_rd_oor  = w_oor_in;
        end else begin
            w_rd_addr = r_addr;
            w_rd_ub   = r_ub;
            w_rd_lb   = r_lb;
            w_rd_oor  = r_oor;
        end
        w_rd_word = r_mem[w_rd_addr];
        if (w_rd_oor) begin
            w_rd_data = 16'h0000;
        end else begin
            w_rd_data = {(w_rd_ub ? 8'h00 : w_rd_word[15:8]),
                         (w_rd_lb ? 8'h00 : w_rd_word[7:0])};
        end
    end

    // Registered Ready pulse and read data, both valid in the completion cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ready    <= 1'b0;
            r_data_out <= 16'h0000;
        end else begin
            r_ready <= w_done_nxt;
            if (w_done_nxt && (w_state_nxt == ST_RD_WAIT)) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign Ready    = r_ready;
    assign Data_out = r_data_out;

endmodule
